// File: rtl/lsu_mem_port_if.sv
// Bundle of the request/response channels and the single-port data-memory
// bus seen by the load/store initiator.
//   slave  : the lsu_mem_port side (accepts requests, drives memory strobes)
//   master : the environment side (CPU memory stage plus data memory)
interface lsu_mem_port_if #(
  parameter int ADDR_W = 32
);
  // Request channel
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  // Response channel
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  // Data-memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_readEn;
  logic              mem_writeEn;
  logic [3:0]        mem_mark;
  logic [31:0]       mem_writeData;
  logic [31:0]       mem_readData;

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_addr, mem_readEn, mem_writeEn, mem_mark, mem_writeData,
    input  mem_readData
  );

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_addr, mem_readEn, mem_writeEn, mem_mark, mem_writeData,
    output mem_readData
  );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store initiator for the single-port data memory. Accepts one request
// at a time, issues a single read or write strobe with a byte-lane mask and
// lane-replicated store data, then returns sign/zero-extended load data (or
// an error flag for misaligned / illegal-size requests) on the response
// channel. Only ADDR_W = 32 is supported.
module lsu_mem_port #(
  parameter int ADDR_W = 32
) (
  input logic           clock,
  input logic           reset,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Request is rejected without touching memory when the size is illegal or
  // the address is not naturally aligned for that size.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: req_is_bad = 1'b0;
      SZ_HALF: req_is_bad = off[0];
      SZ_WORD: req_is_bad = (off != 2'd0);
      default: req_is_bad = 1'b1;
    endcase
  endfunction

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: lane_mask = 4'b0001 << off;
      SZ_HALF: lane_mask = 4'b0011 << off;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane so the memory only
  // needs the mask to pick the correct bytes.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: lane_replicate = {4{wdata[7:0]}};
      SZ_HALF: lane_replicate = {2{wdata[15:0]}};
      default: lane_replicate = wdata;
    endcase
  endfunction

  // Shift the addressed lanes down to bit 0 and extend to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic        [31:0] sh;
    logic signed [7:0]  sb;
    logic signed [15:0] sh16;
    sh   = word >> {off, 3'b000};
    sb   = sh[7:0];
    sh16 = sh[15:0];
    case (size)
      SZ_BYTE: load_extract = sgn ? 32'(sb)   : {24'd0, sh[7:0]};
      SZ_HALF: load_extract = sgn ? 32'(sh16) : {16'd0, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

  state_t r_state;
  state_t w_state_nxt;

  // Latched request
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  // Response holding registers
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_req_ready;
  logic              w_resp_valid;
  logic              w_accept;
  logic              w_resp_done;
  logic              w_bad;
  logic              w_read_en;
  logic              w_write_en;
  logic [3:0]        w_mark;
  logic [1:0]        w_off;

  assign w_off       = r_addr[1:0];
  assign w_bad       = req_is_bad(bus.req_size, bus.req_addr[1:0]);
  assign w_accept    = bus.req_valid && w_req_ready;
  assign w_resp_done = w_resp_valid && bus.resp_ready;

  // Next-state and FSM-decoded outputs; strobes are gated by reset so an
  // access caught by reset in ISSUE never reaches memory.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    w_read_en    = 1'b0;
    w_write_en   = 1'b0;
    w_mark       = 4'b0000;
    case (r_state)
      S_IDLE: begin
        w_req_ready = !reset;
        if (bus.req_valid && !reset) begin
          w_state_nxt = w_bad ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_read_en   = !r_write && !reset;
        w_write_en  = r_write && !reset;
        w_mark      = reset ? 4'b0000 : lane_mask(r_size, w_off);
        w_state_nxt = r_write ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset aborts any in-flight request.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request latch on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_size   <= 2'd0;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
    end else if (w_accept) begin
      r_write  <= bus.req_write;
      r_size   <= bus.req_size;
      r_signed <= bus.req_signed;
      r_addr   <= bus.req_addr;
      r_wdata  <= bus.req_wdata;
    end
  end

  // Response data/error: cleared at accept (stores and errors return 0),
  // loaded from memory in WAIT, held through RESP, cleared on handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= 32'd0;
      r_err   <= w_bad;
    end else if (r_state == S_WAIT) begin
      r_rdata <= load_extract(bus.mem_readData, r_size, w_off, r_signed);
    end else if (w_resp_done) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.resp_valid    = w_resp_valid;
  assign bus.resp_rdata    = r_rdata;
  assign bus.resp_err      = r_err;
  assign bus.mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
  assign bus.mem_readEn    = w_read_en;
  assign bus.mem_writeEn   = w_write_en;
  assign bus.mem_mark      = w_mark;
  assign bus.mem_writeData = lane_replicate(r_size, r_wdata);

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator that drives the single-port data-memory interface (`writeEn`/`readEn`/`mark`/`addr`/`writeData`/`readData`) on behalf of the CPU memory stage. It accepts one load or store at a time over a valid/ready request channel. It converts size and byte offset into a word-aligned address, a lane mask and lane-replicated write data, and issues exactly one memory strobe per request. Load results are extracted and sign- or zero-extended, then returned on a valid/ready response channel. It sits between the memory-stage pipeline logic in `CPUTop` and the data memory.

## Interface
Parameters:
- `ADDR_W`, default 32: address width; only 32 is supported.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  response consumed when high together with `resp_valid`.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_err`  out  1  misaligned address or illegal size.
- `mem_addr`  out  32  `{addr[31:2],2'b00}` of the latched request.
- `mem_readEn`  out  1  read strobe.
- `mem_writeEn`  out  1  write strobe.
- `mem_mark`  out  4  byte-lane mask.
- `mem_writeData`  out  32  lane-replicated store data.
- `mem_readData`  in  32  word from memory; valid the cycle after the edge that sampled `mem_readEn`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready` = 1.
  - On handshake, latch write, size, signed, addr and wdata.
  - Next state is RESP with `resp_err` = 1 when size = 3, half at odd offset, or word at nonzero offset. Otherwise next state is ISSUE.
- ISSUE:
  - Exactly one cycle; drives `mem_readEn` = !write and `mem_writeEn` = write.
  - Next state: WAIT for loads, RESP for stores.
- WAIT: one cycle. Registers the extracted load data into `resp_rdata`; next state RESP.
- RESP:
  - `resp_valid` = 1; `resp_rdata` and `resp_err` hold stable until `resp_ready`.
  - Returns to IDLE on handshake.
- `req_ready` is 1 only in IDLE and is forced to 0 while `reset` is high. Only one request is outstanding.
- `mem_mark`, in ISSUE only (0 in all other states):
  - byte: `4'b0001 << off`
  - half: `4'b0011 << off`
  - word: `4'b1111`
  - `off = addr[1:0]`.
- `mem_writeData`: byte → `{4{wdata[7:0]}}`; half → `{2{wdata[15:0]}}`; word → `wdata`.
- Load extraction: `w = mem_readData >> (8*off)`. Byte takes `w[7:0]` and half takes `w[15:0]`, each sign- or zero-extended per the latched `signed` flag. Word passes through.
- `mem_addr` holds the latched aligned address in all states.
- Error responses never assert a memory strobe.

## Timing
- Handshake at the edge ending cycle T.
- Load: ISSUE in T+1, WAIT in T+2, `resp_valid` in T+3.
- Store: ISSUE in T+1, `resp_valid` in T+2.
- Error: `resp_valid` in T+1.
- Earliest next accept is the cycle after the response handshake. Throughput is one load per 4 cycles or one store per 3 cycles when `resp_ready` = 1.
- Reset values: state IDLE; `resp_valid`, `resp_err`, `resp_rdata`, `mem_readEn`, `mem_writeEn`, `mem_mark`, `mem_addr` and `mem_writeData` are all 0.
- Reset mid-operation in any state aborts the request: state is IDLE after the edge and no response is produced. Strobes are gated by `!reset` in the same cycle, so a store in ISSUE does not write.
- A `req_valid` arriving while not in IDLE is not accepted. The requester holds it per the valid/ready rules.

## Test plan
- Word load at 0x80000104, memory returns 0xDEADBEEF → `mem_readEn` high for exactly T+1, `mem_addr` = 0x80000104, `mem_mark` = 4'hF; in T+3 `resp_valid` = 1, `resp_rdata` = 0xDEADBEEF, `resp_err` = 0.
- Byte load at 0x80000003, memory word 0x80FF1234 → `mem_mark` = 4'b1000. Signed gives `resp_rdata` = 0xFFFFFF80; unsigned gives 0x00000080. Half signed at 0x80000002, same word → 0xFFFF80FF.
- Half store at 0x80000002 with wdata 0x1234ABCD → in T+1 `mem_writeEn` = 1, `mem_mark` = 4'b1100, `mem_writeData` = 0xABCDABCD, `mem_addr` = 0x80000000; in T+2 `resp_valid` = 1 and `resp_rdata` = 0.
- Misaligned word load at 0x80000006, and size = 3 at 0x80000000 → no read or write strobe at any cycle; in T+1 `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0.
- Hold `resp_ready` = 0 for 5 cycles after a load response with `req_valid` held high → `resp_valid`/`resp_rdata` stable, `req_ready` = 0, no strobes. After the handshake, IDLE next cycle and the pending request is accepted.
- Assert `reset` for one cycle during WAIT, and separately during ISSUE of a store → next cycle IDLE with `resp_valid` = 0 and no response ever delivered. `mem_writeEn` = 0 in the reset cycle.
